// File: rtl/plantard_pkg.sv
// Shared definitions for the Plantard operand pre-multiplier: default widths,
// FSM state encoding and iteration-count helpers.
package plantard_pkg;

  localparam int AW_DEF = 32;  // operand a / modulus Q width
  localparam int PW_DEF = 64;  // w / product P width (2*AW)
  localparam int DW_DEF = 8;   // digit width consumed per iteration

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit iterations needed to consume the whole multiplicand.
  function automatic int n_iter(input int aw, input int dw);
    return aw / dw;
  endfunction

  // Counter width able to hold 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plantard_premul_if.sv
// Operand/result handshake bundle between the producer, the pre-multiplier
// and the downstream Plantard reducer.
interface plantard_premul_if
  import plantard_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [PW-1:0] w;
  logic [AW-1:0] q_in;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic [AW-1:0] q_out;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, w, q_in, out_ready,
    input  in_ready, out_valid, p, q_out
  );

  // Pre-multiplier side.
  modport slave (
    input  in_valid, a, w, q_in, out_ready,
    output in_ready, out_valid, p, q_out
  );

endinterface

// File: rtl/plantard_digit_mac.sv
// Combinational DW x PW multiply-accumulate; everything wraps mod 2^PW.
module plantard_digit_mac #(
  parameter int DW = 8,
  parameter int PW = 64
) (
  input  logic [PW-1:0] i_acc,
  input  logic [DW-1:0] i_digit,
  input  logic [PW-1:0] i_w,
  output logic [PW-1:0] o_sum
);

  logic [PW-1:0] w_prod;

  // Both operands are PW wide, so the product is truncated to PW bits and the
  // sum drops its carry-out: exactly the mod 2^PW arithmetic Plantard needs.
  assign w_prod = {{(PW-DW){1'b0}}, i_digit} * i_w;
  assign o_sum  = i_acc + w_prod;

endmodule

// File: rtl/plantard_premul.sv
// Digit-serial computation of P = (a * w) mod 2^PW with the modulus Q carried
// alongside as a sideband, so the reducer receives A=P and Q together.
module plantard_premul
  import plantard_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  plantard_premul_if.slave  bus
);

  localparam int            N    = n_iter(AW, DW);
  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_in_ready;
  logic          w_out_valid;

  logic [AW-1:0] r_a_sh;
  logic [PW-1:0] r_w_sh;
  logic [AW-1:0] r_q;
  logic [PW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_p;
  logic [AW-1:0] r_q_out;
  logic [PW-1:0] w_mac_sum;

  // Lowest digit of the shifting multiplicand times the shifted w, added in.
  plantard_digit_mac #(
    .DW (DW),
    .PW (PW)
  ) u_mac (
    .i_acc   (r_acc),
    .i_digit (r_a_sh[DW-1:0]),
    .i_w     (r_w_sh),
    .o_sum   (w_mac_sum)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt == LAST) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit iteration and result/sideband hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_sh  <= '0;
      r_w_sh  <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q_out <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh <= bus.a;
            r_w_sh <= bus.w;
            r_q    <= bus.q_in;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_acc  <= w_mac_sum;
          r_w_sh <= r_w_sh << DW;
          r_a_sh <= r_a_sh >> DW;
          r_cnt  <= r_cnt + CW'(1);
          // Result registers load only on completion, so p/q_out stay at the
          // last delivered value while the next operand is being processed.
          if (r_cnt == LAST) begin
            r_p     <= w_mac_sum;
            r_q_out <= r_q;
          end
        end
        default: ;  // DONE: hold everything until the result is taken
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.p         = r_p;
  assign bus.q_out     = r_q_out;

endmodule

// File: tb/tb_plantard_premul.sv
// Self-checking bench for plantard_premul: directed cases plus a randomized
// run scored against plain (a*w) mod 2^64 arithmetic.
module tb_plantard_premul;
  import plantard_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plantard_premul_if ifc ();

  plantard_premul dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_p(input logic [31:0] a, input logic [63:0] w);
    return 64'(a) * w;
  endfunction

  // Present an operand set and return at the negedge following acceptance.
  task automatic send(input logic [31:0] a, input logic [63:0] w, input logic [31:0] q);
    int k;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.a        = a;
    ifc.w        = w;
    ifc.q_in     = q;
    k = 0;
    while (!ifc.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ifc.in_ready) check("accept_timeout", 64'(ifc.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!ifc.out_valid && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!ifc.out_valid) check("valid_timeout", 64'(ifc.out_valid), 64'd1);
  endtask

  // Full operation with out_ready held high.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [63:0] w,
                        input logic [31:0] q, input logic [63:0] exp_p);
    int cyc;
    ifc.out_ready = 1'b1;
    send(a, w, q);
    wait_valid(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(N));
    check({tag, "_p"}, ifc.p, exp_p);
    check({tag, "_q"}, 64'(ifc.q_out), 64'(q));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 64'(ifc.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rq;
    logic [63:0] rw, held_p;
    int          cyc, hits, last_hit;
    bit          took;

    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.w         = '0;
    ifc.q_in      = '0;
    ifc.out_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_p", ifc.p, 64'd0);
    check("rst_q_out", 64'(ifc.q_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic and wrap-around products.
    run_op("basic", 32'd3, 64'd5, 32'd1073692673, 64'd15);
    run_op("wrap_max", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd17, 64'hFFFF_FFFF_0000_0001);
    run_op("wrap_zero", 32'd2, 64'h8000_0000_0000_0000, 32'd19, 64'd0);
    run_op("zero_a", 32'd0, 64'h1234_5678_9ABC_DEF0, 32'd23, 64'd0);

    // Backpressure: result and flags hold while out_ready is low.
    ifc.out_ready = 1'b0;
    send(32'd7, 64'h1_0000_0001, 32'd29);
    wait_valid(cyc);
    check("bp_p", ifc.p, 64'h7_0000_0007);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 64'(ifc.out_valid), 64'd1);
      check("bp_hold_ready", 64'(ifc.in_ready), 64'd0);
      check("bp_hold_p", ifc.p, 64'h7_0000_0007);
      check("bp_hold_q", 64'(ifc.q_out), 64'd29);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 64'(ifc.out_valid), 64'd0);
    check("bp_release_ready", 64'(ifc.in_ready), 64'd1);
    check("bp_release_p", ifc.p, 64'h7_0000_0007);

    // in_valid while busy is ignored until the block is idle again.
    send(32'd3, 64'd5, 32'd31);
    ifc.in_valid = 1'b1;
    ifc.a        = 32'd9;
    ifc.w        = 64'd5;
    ifc.q_in     = 32'd77;
    wait_valid(cyc);
    check("busy_first_p", ifc.p, 64'd15);
    check("busy_first_q", 64'(ifc.q_out), 64'd31);
    @(posedge clk);
    @(negedge clk);
    check("busy_back_idle", 64'(ifc.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    wait_valid(cyc);
    check("busy_second_lat", 64'(cyc), 64'(N));
    check("busy_second_p", ifc.p, 64'd45);
    check("busy_second_q", 64'(ifc.q_out), 64'd77);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of RUN discards the operation.
    send(32'd3, 64'd5, 32'd41);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("midrst_p", ifc.p, 64'd0);
    check("midrst_q", 64'(ifc.q_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifc.out_valid) hits++;
    end
    check("midrst_no_result", 64'(hits), 64'd0);

    // Throughput: in_valid and out_ready held high, one result every N+2 cycles.
    ifc.in_valid  = 1'b1;
    ifc.a         = 32'd11;
    ifc.w         = 64'd13;
    ifc.q_in      = 32'd43;
    ifc.out_ready = 1'b1;
    hits     = 0;
    last_hit = 0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.out_valid) begin
        check("tput_p", ifc.p, 64'd143);
        if (hits > 0) check("tput_spacing", 64'(c - last_hit), 64'(N + 2));
        hits++;
        last_hit = c;
      end
    end
    ifc.in_valid = 1'b0;
    check("tput_count", 64'(hits), 64'd6);
    @(negedge clk);

    // Randomized operations with random backpressure.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rw = {$urandom, $urandom};
      rq = $urandom;
      if (i % 50 == 7)  ra = '0;
      if (i % 50 == 23) rw = '0;
      ifc.out_ready = 1'(($urandom_range(0, 1)));
      send(ra, rw, rq);
      wait_valid(cyc);
      check("rand_p", ifc.p, ref_p(ra, rw));
      check("rand_q", 64'(ifc.q_out), 64'(rq));
      held_p = ref_p(ra, rw);
      took   = 1'b0;
      for (int k = 0; k < 12 && !took; k++) begin
        if (k > 0) ifc.out_ready = (k >= 8) ? 1'b1 : 1'(($urandom_range(0, 1)));
        took = ifc.out_ready;
        @(posedge clk);
        @(negedge clk);
        if (!took) check("rand_hold_p", ifc.p, held_p);
      end
      check("rand_handshake", 64'(ifc.out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
